// File: rtl/pacman_soc_irq_ctrl.sv
// Interrupt controller: level/edge capture, pending + mask, claimable lowest-id vector, one CPU irq.
// Latency: irq_in -> pending 2 edges, -> irq_out 3 edges; readdata valid 1 cycle after address.
// Backpressure: none; slave accepts every access on the cycle it is presented.
module pacman_soc_irq_ctrl #(
    parameter int          NUM_IRQ    = 8,
    parameter logic [15:0] RESET_MASK = 16'h0000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               read_n,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic [15:0]        readdata,
    output logic               irq_out
);

    logic [NUM_IRQ-1:0] irq_q, irq_qq;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] edge_sel_q, edge_sel_d;
    logic [15:0]        readdata_q, readdata_d;
    logic               irq_out_q;

    logic [NUM_IRQ-1:0] edge_det;
    logic [NUM_IRQ-1:0] active;
    logic               vec_vld;
    logic [3:0]         vec_id;
    logic               wr, rd, claim;
    logic               pend_wr, mask_wr, esel_wr, force_wr;
    logic               wdata_unused;

    // Upper writedata bits only matter when NUM_IRQ = 16.
    assign wdata_unused = ^writedata;

    assign wr       = chipselect & ~write_n;
    assign rd       = chipselect & ~read_n;
    assign pend_wr  = wr & (address == 3'd1);
    assign mask_wr  = wr & (address == 3'd2);
    assign esel_wr  = wr & (address == 3'd3);
    assign force_wr = wr & (address == 3'd5);

    assign edge_det = irq_q & ~irq_qq;
    assign active   = pending_q & mask_q;

    // Zero-extend a source-wide vector onto the 16-bit register bus.
    function automatic logic [15:0] zext(input logic [NUM_IRQ-1:0] v);
        logic [15:0] r;
        r              = '0;
        r[NUM_IRQ-1:0] = v;
        return r;
    endfunction

    // Lowest-numbered enabled pending source wins the vector.
    always_comb begin
        vec_vld = |active;
        vec_id  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) vec_id = 4'(i);
        end
    end

    // A claim only retires edge-mode sources; level sources stay until the line drops.
    assign claim = rd & (address == 3'd4) & vec_vld & edge_sel_q[vec_id];

    // Pending next state: mode change clears, level follows input, edge sets beat clears.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (esel_wr && (writedata[i] != edge_sel_q[i])) begin
                pending_d[i] = 1'b0;
            end else if (!edge_sel_q[i]) begin
                pending_d[i] = irq_q[i];
            end else if (edge_det[i] || (force_wr && writedata[i])) begin
                pending_d[i] = 1'b1;
            end else if ((pend_wr && writedata[i]) || (claim && (vec_id == 4'(i)))) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    // Configuration register writes.
    always_comb begin
        mask_d     = mask_wr ? writedata[NUM_IRQ-1:0] : mask_q;
        edge_sel_d = esel_wr ? writedata[NUM_IRQ-1:0] : edge_sel_q;
    end

    // Read mux; captured every cycle regardless of read_n.
    always_comb begin
        readdata_d = '0;
        case (address)
            3'd0:    readdata_d = zext(irq_q);
            3'd1:    readdata_d = zext(pending_q);
            3'd2:    readdata_d = zext(mask_q);
            3'd3:    readdata_d = zext(edge_sel_q);
            3'd4:    readdata_d = {vec_vld, 11'd0, vec_id};
            default: readdata_d = '0;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_q      <= '0;
            irq_qq     <= '0;
            pending_q  <= '0;
            mask_q     <= RESET_MASK[NUM_IRQ-1:0];
            edge_sel_q <= '0;
            readdata_q <= '0;
            irq_out_q  <= 1'b0;
        end else begin
            irq_q      <= irq_in;
            irq_qq     <= irq_q;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            edge_sel_q <= edge_sel_d;
            readdata_q <= readdata_d;
            irq_out_q  <= vec_vld;
        end
    end

    assign readdata = readdata_q;
    assign irq_out  = irq_out_q;

endmodule

// File: tb/tb_pacman_soc_irq_ctrl.sv
// Self-checking bench for pacman_soc_irq_ctrl: directed scenarios plus random traffic vs a reference model.
// Latency: model is updated at each rising edge and compared 1 time unit later.
// Backpressure: none; every cycle is checked.
module tb_pacman_soc_irq_ctrl;

    localparam logic [15:0] RST_MASK = 16'h0005;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic [7:0]  irq_in = '0;
    logic [15:0] readdata;
    logic        irq_out;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    bit [7:0]  m_q, m_qq, m_pend, m_mask, m_esel;
    bit [15:0] m_rd;
    bit        m_irq;

    pacman_soc_irq_ctrl #(.NUM_IRQ(8), .RESET_MASK(RST_MASK)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .irq_in     (irq_in),
        .readdata   (readdata),
        .irq_out    (irq_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    endtask

    // Advance the model one edge using the inputs currently driven.
    task automatic model_edge();
        bit [7:0]  act, lsb, edg, set_m, clr_m, chg_m;
        bit [15:0] vec;
        bit        vld, wrs, rds;
        int        id;
        if (!reset_n) begin
            m_q = '0; m_qq = '0; m_pend = '0; m_esel = '0;
            m_mask = RST_MASK[7:0]; m_rd = '0; m_irq = 1'b0;
            return;
        end
        wrs = chipselect && !write_n;
        rds = chipselect && !read_n;
        act = m_pend & m_mask;
        lsb = act & (~act + 8'd1);
        vld = (act != 8'd0);
        id  = vld ? $clog2(lsb) : 0;
        vec = vld ? (16'h8000 | 16'(id)) : 16'h0000;
        case (address)
            3'd0: m_rd = {8'h00, m_q};
            3'd1: m_rd = {8'h00, m_pend};
            3'd2: m_rd = {8'h00, m_mask};
            3'd3: m_rd = {8'h00, m_esel};
            3'd4: m_rd = vec;
            default: m_rd = 16'h0000;
        endcase
        edg   = m_q & ~m_qq;
        set_m = edg | ((wrs && address == 3'd5) ? writedata[7:0] : 8'h00);
        clr_m = ((wrs && address == 3'd1) ? writedata[7:0] : 8'h00)
              | ((rds && address == 3'd4 && (lsb & m_esel) != 0) ? lsb : 8'h00);
        chg_m = (wrs && address == 3'd3) ? (writedata[7:0] ^ m_esel) : 8'h00;
        m_pend = ((((m_pend & ~clr_m) | set_m) & m_esel) | (m_q & ~m_esel)) & ~chg_m;
        m_irq  = vld;
        if (wrs && address == 3'd2) m_mask = writedata[7:0];
        if (wrs && address == 3'd3) m_esel = writedata[7:0];
        m_qq = m_q;
        m_q  = irq_in;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("readdata", readdata, m_rd);
        check("irq_out", {15'd0, irq_out}, {15'd0, m_irq});
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
        chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [15:0] d);
        chipselect = 1'b1; read_n = 1'b0; write_n = 1'b1; address = a;
        tick();
        d = readdata;
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    initial begin
        logic [15:0] d;

        // Reset state
        tick(); tick();
        reset_n = 1'b1;
        rd_reg(3'd2, d); check("rst_mask", d, 16'h0005);
        rd_reg(3'd1, d); check("rst_pend", d, 16'h0000);
        check("rst_irq", {15'd0, irq_out}, 16'h0000);

        // Edge mode bit 0: pulse, latency, claim
        wr_reg(3'd3, 16'h0001);
        wr_reg(3'd2, 16'h0001);
        irq_in = 8'h01; tick();
        irq_in = 8'h00; tick();
        check("e0_irq_k1", {15'd0, irq_out}, 16'h0000);
        tick();
        check("e0_irq_k2", {15'd0, irq_out}, 16'h0001);
        rd_reg(3'd1, d); check("e0_pend", d, 16'h0001);
        rd_reg(3'd4, d); check("e0_vec", d, 16'h8000);
        tick();
        check("e0_irq_clr", {15'd0, irq_out}, 16'h0000);
        rd_reg(3'd1, d); check("e0_pend_clr", d, 16'h0000);

        // Level mode bit 3: claim and W1C have no effect
        wr_reg(3'd3, 16'h0000);
        wr_reg(3'd2, 16'h0008);
        irq_in = 8'h08; tick(); tick(); tick();
        rd_reg(3'd4, d); check("lv_vec", d, 16'h8003);
        wr_reg(3'd1, 16'h0008);
        rd_reg(3'd1, d); check("lv_pend", d, 16'h0008);
        irq_in = 8'h00; tick(); tick();
        check("lv_irq_e2", {15'd0, irq_out}, 16'h0001);
        tick();
        check("lv_irq_e3", {15'd0, irq_out}, 16'h0000);

        // Edge bits 1 and 2: priority and successive claims
        wr_reg(3'd3, 16'h0006);
        wr_reg(3'd2, 16'h0006);
        irq_in = 8'h06; tick();
        irq_in = 8'h00; tick(); tick();
        rd_reg(3'd4, d); check("pr_vec1", d, 16'h8001);
        rd_reg(3'd4, d); check("pr_vec2", d, 16'h8002);
        rd_reg(3'd4, d); check("pr_vec0", d, 16'h0000);
        tick();
        check("pr_irq", {15'd0, irq_out}, 16'h0000);

        // Set beats W1C, FORCE, mask gating of irq_out only
        wr_reg(3'd3, 16'h0030);
        irq_in = 8'h10; tick();
        wr_reg(3'd1, 16'h0010);
        rd_reg(3'd1, d); check("w1c_vs_edge", d, 16'h0010);
        wr_reg(3'd5, 16'h0020);
        rd_reg(3'd1, d); check("force", d, 16'h0030);
        wr_reg(3'd2, 16'h0030); tick();
        check("unmask_irq", {15'd0, irq_out}, 16'h0001);
        wr_reg(3'd2, 16'h0000); tick();
        check("mask_irq", {15'd0, irq_out}, 16'h0000);
        rd_reg(3'd1, d); check("mask_pend", d, 16'h0030);

        // Reset mid-operation with bit 0 held high
        wr_reg(3'd3, 16'h0031);
        irq_in = 8'h11; tick(); tick();
        rd_reg(3'd1, d); check("pre_rst_pend", d, 16'h0031);
        reset_n = 1'b0; tick();
        check("mid_rst_rd", readdata, 16'h0000);
        check("mid_rst_irq", {15'd0, irq_out}, 16'h0000);
        reset_n = 1'b1; tick(); tick();
        rd_reg(3'd1, d); check("post_rst_pend0", {15'd0, d[0]}, 16'h0001);

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            reset_n    = ($urandom_range(0, 299) != 0);
            chipselect = $urandom_range(0, 1);
            read_n     = $urandom_range(0, 1);
            write_n    = ($urandom_range(0, 2) != 0);
            address    = 3'($urandom_range(0, 7));
            writedata  = 16'($urandom);
            irq_in     = irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pacman_soc_irq_ctrl.md
Name: pacman_soc_irq_ctrl

Overview:
- Interrupt controller directly downstream of the interval timer and the other SoC interrupt sources.
- Captures each source's interrupt line as level or rising-edge, holds it in a pending register, and applies a mask.
- Drives one aggregated interrupt to the CPU.
- The CPU reads a vector register that reports, and atomically claims, the lowest-numbered enabled pending source.

Parameters:
- NUM_IRQ, 8, number of interrupt sources, legal range 1..16; bit i corresponds to source i.
- RESET_MASK, 16'h0000, reset value of the MASK register; bits at or above NUM_IRQ are ignored.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- address  input  3  register select, word-addressed.
- chipselect  input  1  slave select.
- read_n  input  1  read strobe, active-low; only needed for the claim side effect.
- write_n  input  1  write strobe, active-low.
- writedata  input  16  write data.
- irq_in  input  NUM_IRQ  interrupt lines from sources, same clock domain.
- readdata  output  16  registered read data.
- irq_out  output  1  aggregated interrupt to the CPU, registered.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low: reset_n low at a clk rising edge resets every register. No asynchronous reset path.
- Reset values: readdata=0, irq_out=0, PENDING=0, EDGE_SEL=0, MASK=RESET_MASK, irq_q=0, irq_qq=0.
- Input stage: irq_q <= irq_in and irq_qq <= irq_q on every edge. edge_i = irq_q[i] & ~irq_qq[i].
- Strobes: wr = chipselect & ~write_n; rd = chipselect & ~read_n.
- Register map:
  - 0 STATUS (RO): irq_q.
  - 1 PENDING (R/W1C).
  - 2 MASK (RW).
  - 3 EDGE_SEL (RW): 1 = edge mode, 0 = level mode.
  - 4 VECTOR (RO): bit15 = valid, bits3:0 = id, other bits 0.
  - 5 FORCE (WO): write 1 sets pending; reads 0.
  - 6 and 7: read 0, writes ignored.
  - Bits at or above NUM_IRQ read 0 and ignore writes.
- Pending, level mode: PENDING[i] <= irq_q[i] every edge. W1C, FORCE and claim have no effect on the bit.
- Pending, edge mode, next-value priority:
  1. Set if edge_i, or a FORCE write with writedata[i]=1.
  2. Otherwise clear if a PENDING write with writedata[i]=1, or a claim of id i.
  3. Otherwise hold.
  - Set wins over a simultaneous clear.
- EDGE_SEL write: any bit whose mode changes has its pending bit cleared on the same edge. A bit switched to level mode then follows irq_q from the next edge.
- Enabled set: active = PENDING & MASK.
- VECTOR: valid = |active; id = index of the lowest set bit of active; id = 0 when valid = 0.
- Claim: rd & address==4 & valid & EDGE_SEL[id]. Clears PENDING[id] on the same edge that readdata captures the vector, so readdata shows the pre-claim value. A claim with valid=0 does nothing.
- readdata: readdata <= read mux of address on every edge, independent of read_n. It is valid one cycle after address is presented. Read side effects require rd.
- irq_out: irq_out <= |active, one cycle after PENDING/MASK change.
- Latency, edge mode: irq_in rises before edge k. irq_q=1 at k, PENDING at k+1, irq_out at k+2.
- Latency, level mode: same pipeline. irq_out deasserts 3 edges after irq_in falls.
- Mask: does not gate capture. A masked edge stays pending and asserts irq_out once unmasked.
- Simultaneous writes on one edge to different addresses are impossible (single port). A FORCE write and an input edge on the same bit set it once.
- Reset mid-operation: all pending state lost, and edges in flight are dropped. irq_q and irq_qq reset to 0, so an input held high through reset produces an edge two edges after reset release.

Test Plan:
- Reset, then read MASK with RESET_MASK=16'h0005 -> readdata=16'h0005; read PENDING -> 0; irq_out=0.
- EDGE_SEL=16'h0001, MASK=16'h0001, pulse irq_in[0] for 1 cycle before edge k -> PENDING=16'h0001 at k+1, irq_out=1 at k+2. Read VECTOR -> 16'h8000, PENDING=0 after the claim, irq_out=0 one edge later.
- Level mode on bit 3, MASK=16'h0008, hold irq_in[3]=1 -> VECTOR=16'h8003. Claim and W1C 16'h0008 -> PENDING stays 16'h0008. Drop irq_in[3] -> irq_out=0 three edges later.
- Edge mode bits 1 and 2 both pending, MASK=16'h0006 -> VECTOR=16'h8001. Claim -> VECTOR=16'h8002. Claim -> VECTOR=16'h0000, irq_out=0.
- Edge bit 4: W1C 16'h0010 on the same edge a new edge_4 arrives -> PENDING[4] stays 1. FORCE 16'h0020 on edge-mode bit 5 -> PENDING[5]=1. MASK=0 -> irq_out=0 with PENDING unchanged.
- Edge bit 0 pending; assert reset_n low for one edge -> PENDING=0, irq_out=0, readdata=0. A held irq_in[0]=1 re-sets PENDING[0] at the 3rd edge after release.
